// File: rtl/conv1_layer1_dense_acc.sv
// rtl/conv1_layer1_dense_acc.sv - conv1 layer1 dense product reduce, accumulate, ReLU/shift/saturate, output FIFO

module conv1_layer1_dense_acc_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     wr_tdata,
  input  logic             wr_tvalid,
  output logic             wr_tready,
  output logic [W-1:0]     rd_tdata,
  output logic             rd_tvalid,
  input  logic             rd_tready,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             rd_pop;
  logic             wr_en;

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign rd_tvalid = (count != '0);
  assign rd_pop    = rd_tvalid && rd_tready;
  assign wr_tready = (count != CNT_W'(DEPTH)) || rd_pop;
  assign wr_en     = wr_tvalid && wr_tready;
  assign rd_tdata  = rd_tvalid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_tdata;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (rd_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (wr_en && !rd_pop) begin
        count <= count + CNT_W'(1);
      end else if (!wr_en && rd_pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

module conv1_layer1_dense_acc #(
  parameter int LANES      = 25,
  parameter int LANE_W     = 16,
  parameter int BEATS      = 8,
  parameter int SHIFT      = 4,
  parameter int OUT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*LANE_W-1:0] mult_res,
  input  logic                    mult_res_v,
  output logic                    need_data,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_v,
  input  logic                    out_ready,
  output logic                    overflow
);

  localparam int SUM_W = LANE_W + 5;
  localparam int ACC_W = 32;
  localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((64'd1 << OUT_W) - 64'd1);

  logic signed [SUM_W-1:0] sum_c;
  logic signed [SUM_W-1:0] s1_sum;
  logic                    s1_v;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum_ext;
  logic signed [ACC_W-1:0] acc_next;
  logic [BC_W-1:0]         beat_cnt;
  logic                    final_beat;
  logic [ACC_W-1:0]        relu;
  logic [ACC_W-1:0]        shifted;
  logic [OUT_W-1:0]        result;
  logic                    push_ready;
  logic [CNT_W-1:0]        fifo_count;

  // Lane reduction; 5 guard bits cover the growth of 25 lanes.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_c = sum_c + SUM_W'($signed(mult_res[LANE_W*i +: LANE_W]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_sum <= '0;
    end else begin
      s1_v <= mult_res_v;
      if (mult_res_v) begin
        s1_sum <= sum_c;
      end
    end
  end

  always_comb begin
    sum_ext    = ACC_W'(s1_sum);
    acc_next   = (beat_cnt == '0) ? sum_ext : acc + sum_ext;
    final_beat = s1_v && (beat_cnt == BC_W'(BEATS - 1));
    relu       = acc_next[ACC_W-1] ? '0 : acc_next;
    // relu is never negative, so a logical shift equals the arithmetic one.
    shifted    = relu >> SHIFT;
    result     = (shifted > SAT_MAX) ? SAT_MAX[OUT_W-1:0] : shifted[OUT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      beat_cnt <= '0;
    end else if (s1_v) begin
      acc      <= acc_next;
      beat_cnt <= final_beat ? '0 : beat_cnt + BC_W'(1);
    end
  end

  conv1_layer1_dense_acc_fifo #(
    .W     (OUT_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_tdata  (result),
    .wr_tvalid (final_beat),
    .wr_tready (push_ready),
    .rd_tdata  (out_data),
    .rd_tvalid (out_v),
    .rd_tready (out_ready),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (final_beat && !push_ready) begin
      overflow <= 1'b1;
    end
  end

  // Two results can already be in the pipe when upstream sees need_data drop.
  assign need_data = (fifo_count <= CNT_W'(FIFO_DEPTH - 2));

endmodule

// File: tb/tb_conv1_layer1_dense_acc.sv
// tb/tb_conv1_layer1_dense_acc.sv - directed-vector bench for conv1_layer1_dense_acc

module tb_conv1_layer1_dense_acc;

  logic         clk;
  logic         rst;
  logic [399:0] mult_res;
  logic         mult_res_v;
  logic         need_data;
  logic [15:0]  out_data;
  logic         out_v;
  logic         out_ready;
  logic         overflow;

  int           n_vec;
  int           n_bad;
  logic [15:0]  got_q[$];
  int           gaps[8] = '{0, 3, 1, 5, 2, 4, 0, 1};

  conv1_layer1_dense_acc dut (
    .clk        (clk),
    .rst        (rst),
    .mult_res   (mult_res),
    .mult_res_v (mult_res_v),
    .need_data  (need_data),
    .out_data   (out_data),
    .out_v      (out_v),
    .out_ready  (out_ready),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_v && out_ready) got_q.push_back(out_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic [15:0] v);
    for (int i = 0; i < 25; i++) mult_res[16*i +: 16] = v;
    mult_res_v = 1'b1;
    idle(1);
    mult_res_v = 1'b0;
  endtask

  task automatic point(input logic [15:0] v);
    for (int b = 0; b < 8; b++) beat(v);
  endtask

  task automatic wait_outputs(input int n);
    int cyc;
    cyc = 0;
    while (got_q.size() < n && cyc < 200) begin
      idle(1);
      cyc++;
    end
    if (got_q.size() < n) check("wait_timeout", got_q.size(), n);
  endtask

  initial begin
    n_vec      = 0;
    n_bad      = 0;
    rst        = 1'b1;
    mult_res   = '0;
    mult_res_v = 1'b0;
    out_ready  = 1'b1;
    idle(3);
    check("rst_need_data", need_data, 1);
    check("rst_out_v", out_v, 0);
    check("rst_out_data", out_data, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    idle(1);

    // basic: 8 x 25 x 1 = 200, >>4 = 12, visible 2 cycles after last beat
    point(16'h0001);
    check("basic_lat1", out_v, 0);
    idle(1);
    check("basic_out_v", out_v, 1);
    check("basic_data", out_data, 12);
    idle(1);
    check("basic_one_cycle", out_v, 0);
    got_q.delete();

    point(16'hFFFF);
    wait_outputs(1);
    check("relu_data", got_q.size() > 0 ? got_q[0] : 16'hDEAD, 0);
    got_q.delete();

    point(16'h7FFF);
    wait_outputs(1);
    check("sat_data", got_q.size() > 0 ? got_q[0] : 16'hDEAD, 16'hFFFF);
    got_q.delete();

    for (int k = 0; k < 8; k++) begin
      beat(16'h0001);
      idle(gaps[k]);
    end
    point(16'h0002);
    wait_outputs(2);
    check("gap_first", got_q.size() > 0 ? got_q[0] : 16'hDEAD, 12);
    check("gap_second", got_q.size() > 1 ? got_q[1] : 16'hDEAD, 25);
    got_q.delete();

    // backpressure: count p after point p; need_data low from count 3
    out_ready = 1'b0;
    for (int p = 1; p <= 5; p++) begin
      point(16'h0001);
      idle(1);
      check($sformatf("bp_need_data_%0d", p), need_data, (p <= 2) ? 1 : 0);
      check($sformatf("bp_overflow_%0d", p), overflow, (p == 5) ? 1 : 0);
    end
    check("bp_head_v", out_v, 1);
    check("bp_head_data", out_data, 12);
    check("bp_no_pops", got_q.size(), 0);
    out_ready = 1'b1;
    idle(10);
    check("drain_count", got_q.size(), 4);
    for (int k = 0; k < 4; k++) check($sformatf("drain_%0d", k), k < got_q.size() ? got_q[k] : 16'hDEAD, 12);
    check("drain_need_data", need_data, 1);
    check("drain_out_v", out_v, 0);
    check("drain_overflow_sticky", overflow, 1);
    got_q.delete();

    for (int b = 0; b < 5; b++) beat(16'h0007);
    rst = 1'b1;
    #1;
    check("mid_rst_out_v", out_v, 0);
    idle(1);
    check("mid_rst_out_v2", out_v, 0);
    check("mid_rst_overflow", overflow, 0);
    rst = 1'b0;
    idle(1);
    check("post_rst_out_v", out_v, 0);
    point(16'h0001);
    wait_outputs(1);
    check("post_rst_data", got_q.size() > 0 ? got_q[0] : 16'hDEAD, 12);
    idle(10);
    check("post_rst_single", got_q.size(), 1);
    check("post_rst_overflow", overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/conv1_layer1_dense_acc.md
# conv1_layer1_dense_acc

Downstream stage of the conv1 layer1 dense matrix-multiply unit. It consumes the 400-bit product vector and its valid strobe, reduces the 25 signed 16-bit lanes per beat with an adder tree, and accumulates a fixed number of beats per output point. Each finished accumulation goes through ReLU, right shift and saturation, then into a small output FIFO with valid/ready. It drives need_data back to the feature/A-matrix sources as flow control.

## Interface
Parameters:
- LANES, 25, product lanes per beat
- LANE_W, 16, lane width; two's complement
- BEATS, 8, product beats summed per output point
- SHIFT, 4, arithmetic right shift applied after ReLU
- OUT_W, 16, unsigned output width
- FIFO_DEPTH, 4, output FIFO entries

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mult_res  in  LANES*LANE_W  product vector; lane i = mult_res[LANE_W*i +: LANE_W]
- mult_res_v  in  1  mult_res valid for this cycle
- need_data  out  1  upstream may issue more product beats
- out_data  out  OUT_W  FIFO head value
- out_v  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head this cycle
- overflow  out  1  sticky: a result was dropped because the FIFO was full

## Operation
- Stage 1: when mult_res_v=1, sign-extend all lanes and sum them to LANE_W+5 bits. Register the sum and a stage-1 valid.
- Stage 2: when stage-1 valid=1:
  - If beat_cnt==0, acc = sum. Otherwise acc = acc + sum.
  - acc is 32 bits signed; no overflow is possible at the default parameters.
  - beat_cnt counts 0..BEATS-1 and wraps to 0 after the final beat.
- Final beat (beat_cnt==BEATS-1): compute result from acc_next (acc plus the current sum).
  - ReLU: negative becomes 0.
  - Arithmetic shift right by SHIFT.
  - Saturate to 2^OUT_W-1.
  - Write result to the FIFO.
- FIFO is first-word-fall-through:
  - out_data and out_v reflect the head entry.
  - Pop occurs when out_v && out_ready.
- Push and pop in the same cycle:
  - Both happen.
  - Count is unchanged.
  - This is legal when full.
- Final beat while count==FIFO_DEPTH and no pop that cycle:
  - The result is dropped.
  - overflow is set and stays at 1 until rst.
  - Accumulator and beat_cnt still advance and wrap normally.
- need_data = (count <= FIFO_DEPTH-2). This is combinational from the registered count and leaves headroom for two in-flight results.
- mult_res_v gaps of any length between beats do not affect results. Partial accumulations persist indefinitely.
- Reset values:
  - need_data=1
  - out_v=0
  - out_data=0
  - overflow=0
  - acc=0, beat_cnt=0, stage-1 valid=0
  - FIFO empty
- Reset mid-accumulation discards partial sums and all FIFO contents. The next valid beat starts a new point.

## Timing
- Beat sampled at edge E1 (mult_res_v=1 in the preceding cycle) produces the stage-1 register.
- Stage 2 updates acc at E2.
- On a final beat, the FIFO write is at E2. If the FIFO was empty, out_v=1 in the cycle after E2, i.e. 2 cycles after the final beat's input cycle.
- Back-to-back beats are accepted every cycle. Throughput is one beat per cycle and one output per BEATS cycles.
- out_data is stable while out_v=1 and out_ready=0.
- need_data reflects the count after each edge. Upstream must stop issuing within 2 cycles of need_data falling.

## Test plan
- Basic accumulate:
  - Stimulus: 8 back-to-back beats, all lanes 0x0001, out_ready=1.
  - Required: out_data=12 (200>>4), with out_v for one cycle, 2 cycles after the 8th beat.
- ReLU:
  - Stimulus: 8 beats, all lanes 0xFFFF (-1).
  - Required: out_data=0 (acc=-200 clamped by ReLU).
- Saturation:
  - Stimulus: 8 beats, all lanes 0x7FFF.
  - Required: acc=6553400; 409587 after shift; out_data=0xFFFF.
- Gapped input:
  - Stimulus: 8 beats of lanes=1 with 0–5 idle cycles between them, then 8 beats of lanes=2.
  - Required: outputs 12 then 25 (400>>4), in order.
- Backpressure and overflow:
  - Stimulus: out_ready=0; feed 5 points of lanes=1.
  - Required: need_data falls once count=3; 4 entries of 12 are held; the 5th result is dropped and overflow=1.
  - Then: raising out_ready drains exactly 4 values, after which need_data=1.
- Reset mid-operation:
  - Stimulus: 5 beats of lanes=7, rst pulse, then 8 beats of lanes=1.
  - Required: single output of 12; overflow=0; out_v=0 during and immediately after rst.
